// File: rtl/puf_challenge_sequencer.sv
// PUF challenge sequencer: applies a challenge, samples the response
// repeatedly and returns a majority-voted result with an instability mask.
module puf_challenge_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_SAMPLES   = 7,
    parameter int SAMPLE_GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] challenge_in,
    output logic       busy,
    output logic [7:0] puf_challenge,
    output logic       puf_en,
    input  logic [7:0] puf_response,
    output logic       sample_strobe,
    output logic [7:0] resp_out,
    output logic [7:0] unstable_mask,
    output logic       resp_valid,
    input  logic       resp_ready
);

    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int GW = $clog2(SAMPLE_GAP + 1);

    localparam logic [CW-1:0] HALF   = CW'(NUM_SAMPLES / 2);
    localparam logic [CW-1:0] NS_ALL = CW'(NUM_SAMPLES);
    localparam logic [CW-1:0] NS_M1  = CW'(NUM_SAMPLES - 1);
    localparam logic [SW-1:0] SC_M1  = SW'(SETTLE_CYCLES - 1);
    localparam logic [GW-1:0] SG_M1  = GW'(SAMPLE_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        VOTE,
        OUTPUT
    } state_t;

    state_t state, state_nxt;

    logic [SW-1:0] settle_cnt;
    logic [GW-1:0] gap_cnt;
    logic [CW-1:0] samp_cnt;
    logic [CW-1:0] bit_cnt [8];
    logic          accept;
    logic          capture;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (gap_cnt == '0) begin
                    capture = 1'b1;
                    if (samp_cnt == NS_M1) state_nxt = VOTE;
                end
            end
            VOTE: state_nxt = OUTPUT;
            OUTPUT: begin
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign puf_en        = (state == SETTLE) || (state == SAMPLE);
    assign sample_strobe = capture;
    assign resp_valid    = (state == OUTPUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt    <= '0;
            gap_cnt       <= '0;
            samp_cnt      <= '0;
            puf_challenge <= '0;
            resp_out      <= '0;
            unstable_mask <= '0;
            for (int i = 0; i < 8; i++) bit_cnt[i] <= '0;
        end else begin
            if (accept) begin
                puf_challenge <= challenge_in;
                settle_cnt    <= SC_M1;
                gap_cnt       <= '0;
                samp_cnt      <= '0;
                for (int i = 0; i < 8; i++) bit_cnt[i] <= '0;
            end
            if (state == SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - SW'(1);
            // The first SAMPLE cycle is a capture; later ones wait out the gap
            if (state == SAMPLE) begin
                if (capture) begin
                    gap_cnt  <= SG_M1;
                    samp_cnt <= samp_cnt + CW'(1);
                    for (int i = 0; i < 8; i++)
                        bit_cnt[i] <= bit_cnt[i] + CW'(puf_response[i]);
                end else begin
                    gap_cnt <= gap_cnt - GW'(1);
                end
            end
            if (state == VOTE) begin
                for (int i = 0; i < 8; i++) begin
                    resp_out[i]      <= (bit_cnt[i] > HALF);
                    unstable_mask[i] <= (bit_cnt[i] != '0) &&
                                        (bit_cnt[i] != NS_ALL);
                end
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: directed and random runs checked
// against a popcount-based majority model.
module tb_puf_challenge_sequencer;

    localparam int SC  = 4;
    localparam int NS  = 7;
    localparam int SG  = 2;
    localparam int LAT = SC + 1 + (NS - 1) * SG + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] challenge_in;
    logic       busy;
    logic [7:0] puf_challenge;
    logic       puf_en;
    logic [7:0] puf_response;
    logic       sample_strobe;
    logic [7:0] resp_out;
    logic [7:0] unstable_mask;
    logic       resp_valid;
    logic       resp_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] smp [NS];

    puf_challenge_sequencer #(
        .SETTLE_CYCLES(SC),
        .NUM_SAMPLES(NS),
        .SAMPLE_GAP(SG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .challenge_in(challenge_in),
        .busy(busy),
        .puf_challenge(puf_challenge),
        .puf_en(puf_en),
        .puf_response(puf_response),
        .sample_strobe(sample_strobe),
        .resp_out(resp_out),
        .unstable_mask(unstable_mask),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " puf_en"}, puf_en, 0);
        chk({tag, " strobe"}, sample_strobe, 0);
        chk({tag, " valid"}, resp_valid, 0);
        chk({tag, " chal"}, puf_challenge, 0);
        chk({tag, " resp"}, resp_out, 0);
        chk({tag, " mask"}, unstable_mask, 0);
    endtask

    // Majority per bit over the sample set, plus non-unanimous flag
    task automatic model(output logic [7:0] er, output logic [7:0] em);
        int ones;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int k = 0; k < NS; k++) ones += int'(smp[k][b]);
            er[b] = (ones > NS / 2);
            em[b] = (ones != 0) && (ones != NS);
        end
    endtask

    function automatic int cap_idx(input int c);
        int d;
        d = c - SC - 1;
        if (d < 0 || d % SG != 0 || d / SG >= NS) return -1;
        return d / SG;
    endfunction

    // Called #1 after an edge; returns #1 after the handshake edge
    task automatic run(input logic [7:0] chal, input int hold,
                       input bit poke);
        logic [7:0] er, em;
        int k;
        model(er, em);
        start = 1'b1;
        challenge_in = chal;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        challenge_in = 8'($urandom);
        chk("acc busy", busy, 1);
        chk("acc puf_en", puf_en, 1);
        chk("acc chal", puf_challenge, chal);
        for (int c = 1; c <= LAT; c++) begin
            k = cap_idx(c);
            puf_response = (k >= 0) ? smp[k] : 8'($urandom);
            resp_ready = 1'($urandom);
            if (poke && c == SC + 4) begin
                start = 1'b1;
                challenge_in = 8'h11;
            end
            @(negedge clk);
            chk($sformatf("strobe c%0d", c), sample_strobe, (k >= 0));
            chk($sformatf("puf_en c%0d", c), puf_en, (c < LAT));
            chk($sformatf("early valid c%0d", c), resp_valid, 0);
            @(posedge clk);
            #1;
            start = 1'b0;
            resp_ready = 1'b0;
        end
        chk("chal held", puf_challenge, chal);
        chk("latency valid", resp_valid, 1);
        chk("resp", resp_out, er);
        chk("mask", unstable_mask, em);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("bp valid", resp_valid, 1);
            chk("bp busy", busy, 1);
            chk("bp resp", resp_out, er);
            chk("bp mask", unstable_mask, em);
        end
        resp_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            challenge_in = 8'h11;
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        start = 1'b0;
        chk("hs valid", resp_valid, 0);
        chk("hs busy", busy, 0);
        chk("hs resp", resp_out, er);
        chk("hs mask", unstable_mask, em);
        chk("hs chal", puf_challenge, chal);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        challenge_in = 8'h00;
        puf_response = 8'h00;
        resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            challenge_in = 8'($urandom);
            puf_response = 8'($urandom);
            @(posedge clk);
            #1;
        end
        chk_reset_vals("idle");

        for (int k = 0; k < NS; k++) smp[k] = 8'hA5;
        run(8'h3C, 0, 1'b0);
        chk("stable resp", resp_out, 8'hA5);
        chk("stable mask", unstable_mask, 8'h00);

        for (int k = 0; k < NS; k++)
            smp[k] = (k < 3) ? 8'hA5 : (k == 3) ? 8'hA4 : 8'h24;
        run(8'h5E, 0, 1'b0);
        chk("edge resp", resp_out, 8'hA4);
        chk("edge mask", unstable_mask, 8'h81);

        for (int k = 0; k < NS; k++) smp[k] = (k == 0) ? 8'hAD : 8'hA5;
        run(8'hC3, 10, 1'b0);
        chk("bit3 resp", resp_out, 8'hA5);
        chk("bit3 mask", unstable_mask, 8'h08);

        for (int k = 0; k < NS; k++) smp[k] = 8'($urandom);
        run(8'h96, 2, 1'b1);
        for (int k = 0; k < NS; k++) smp[k] = 8'h3F;
        run(8'h11, 0, 1'b0);
        chk("restart chal", puf_challenge, 8'h11);

        start = 1'b1;
        challenge_in = 8'h77;
        @(posedge clk);
        #1;
        start = 1'b0;
        puf_response = 8'hFF;
        for (int c = 1; c < SC + 1 + 2 * SG + 1; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("abort");
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort hold valid", resp_valid, 0);
        end
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("post abort valid", resp_valid, 0);
        end
        for (int k = 0; k < NS; k++) smp[k] = 8'h5A;
        run(8'h42, 1, 1'b0);
        chk("post abort resp", resp_out, 8'h5A);
        chk("post abort mask", unstable_mask, 8'h00);

        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NS; k++) smp[k] = 8'($urandom);
            run(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
